// File: rtl/freq_trim_nco.sv
// AFC command consumer: integrates increase/decrease commands into a saturating signed trim,
// offsets the base frequency word with it and drives a phase-accumulator NCO.
module freq_trim_nco #(
    parameter int unsigned TRIM_W   = 12,
    parameter int unsigned FCW_W    = 16,
    parameter int unsigned STEP     = 1,
    parameter int unsigned HOLDOFF  = 12,
    parameter int unsigned LOCK_CNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     afc_en,
    input  logic [1:0]               freq_mod,
    input  logic                     trim_clr,
    input  logic [FCW_W-1:0]         base_fcw,
    output logic signed [TRIM_W-1:0] trim_out,
    output logic [FCW_W-1:0]         fcw,
    output logic [FCW_W-1:0]         phase,
    output logic                     sat,
    output logic                     lock
);

    localparam int unsigned HoldW = $clog2(HOLDOFF + 1);
    localparam int unsigned AltW  = $clog2(LOCK_CNT + 1);
    localparam int TrimMax = int'((2 ** (TRIM_W - 1)) - 1);
    localparam int TrimMin = -TrimMax - 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF - 1);
    localparam logic [AltW-1:0]  AltMax   = AltW'(LOCK_CNT);

    logic signed [TRIM_W-1:0] trim_q, trim_d;
    logic [HoldW-1:0]         hold_q, hold_d;
    logic [AltW-1:0]          alt_q, alt_d;
    logic                     last_dir_q, last_dir_d;
    logic                     last_vld_q, last_vld_d;
    logic                     lock_q, lock_d;
    logic [FCW_W-1:0]         fcw_q, fcw_d;
    logic [FCW_W-1:0]         phase_q, phase_d;

    logic cmd_valid;
    logic dir_dn;
    logic accept;
    int   trim_sum;

    assign cmd_valid = (freq_mod == 2'b01) || (freq_mod == 2'b10);
    assign dir_dn    = freq_mod[1];
    assign accept    = en && afc_en && (hold_q == '0) && cmd_valid && !trim_clr;

    always_comb begin
        trim_d     = trim_q;
        hold_d     = hold_q;
        alt_d      = alt_q;
        last_dir_d = last_dir_q;
        last_vld_d = last_vld_q;
        lock_d     = lock_q;

        // Integer-domain sum so the rails can be detected before truncation.
        trim_sum = int'(trim_q) + (dir_dn ? -int'(STEP) : int'(STEP));
        if (trim_sum > TrimMax) begin
            trim_sum = TrimMax;
        end else if (trim_sum < TrimMin) begin
            trim_sum = TrimMin;
        end

        if (trim_clr) begin
            trim_d     = '0;
            hold_d     = '0;
            alt_d      = '0;
            last_vld_d = 1'b0;
            lock_d     = 1'b0;
        end else if (en) begin
            if (!afc_en) begin
                hold_d     = '0;
                alt_d      = '0;
                last_vld_d = 1'b0;
                lock_d     = 1'b0;
            end else if (accept) begin
                trim_d = TRIM_W'(trim_sum);
                hold_d = HoldLoad;
                if (last_vld_q && (dir_dn != last_dir_q)) begin
                    alt_d = (alt_q == AltMax) ? AltMax : alt_q + AltW'(1);
                end else begin
                    alt_d = '0;
                end
                last_dir_d = dir_dn;
                last_vld_d = 1'b1;
                lock_d     = (alt_d == AltMax);
            end else if (hold_q != '0) begin
                hold_d = hold_q - HoldW'(1);
            end
        end
    end

    // fcw tracks base_fcw every clock; only the accumulator is sample-rate gated.
    always_comb begin
        fcw_d   = base_fcw + FCW_W'(trim_q);
        phase_d = en ? phase_q + fcw_q : phase_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trim_q     <= '0;
            hold_q     <= '0;
            alt_q      <= '0;
            last_dir_q <= 1'b0;
            last_vld_q <= 1'b0;
            lock_q     <= 1'b0;
            fcw_q      <= '0;
            phase_q    <= '0;
        end else begin
            trim_q     <= trim_d;
            hold_q     <= hold_d;
            alt_q      <= alt_d;
            last_dir_q <= last_dir_d;
            last_vld_q <= last_vld_d;
            lock_q     <= lock_d;
            fcw_q      <= fcw_d;
            phase_q    <= phase_d;
        end
    end

    assign trim_out = trim_q;
    assign fcw      = fcw_q;
    assign phase    = phase_q;
    assign lock     = lock_q;
    assign sat      = (trim_q == TRIM_W'(TrimMax)) || (trim_q == TRIM_W'(TrimMin));

endmodule

// File: tb/tb_freq_trim_nco.sv
// Directed bench for freq_trim_nco: stimulus pushes expected output values into a scoreboard,
// a negedge monitor pops and compares them against the DUT.
module tb_freq_trim_nco;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic               afc_en;
    logic [1:0]         freq_mod;
    logic               trim_clr;
    logic [15:0]        base_fcw;
    logic signed [11:0] trim_out;
    logic [15:0]        fcw;
    logic [15:0]        phase;
    logic               sat;
    logic               lock;

    freq_trim_nco dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .afc_en   (afc_en),
        .freq_mod (freq_mod),
        .trim_clr (trim_clr),
        .base_fcw (base_fcw),
        .trim_out (trim_out),
        .fcw      (fcw),
        .phase    (phase),
        .sat      (sat),
        .lock     (lock)
    );

    always #5 clk = ~clk;

    localparam int KTrim  = 0;
    localparam int KFcw   = 1;
    localparam int KPhase = 2;
    localparam int KSat   = 3;
    localparam int KLock  = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] expv;
        int          at;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] act;

    logic [1:0] alt_dirs [7] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10};
    logic [11:0] alt_trim [7] = '{12'd1, 12'd0, 12'd1, 12'd0, 12'd1, 12'd0, 12'hFFF};
    logic        alt_lock [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            cur = sbq.pop_front();
            case (cur.kind)
                KTrim:   act = {20'd0, trim_out};
                KFcw:    act = {16'd0, fcw};
                KPhase:  act = {16'd0, phase};
                KSat:    act = {31'd0, sat};
                default: act = {31'd0, lock};
            endcase
            checks++;
            if (act !== cur.expv) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                         cur.name, act, cur.expv, cyc);
            end
        end
    end

    task automatic push_exp(input string name, input int kind, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.expv = v;
        e.at   = cyc;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        afc_en   = 1'b0;
        freq_mod = 2'b00;
        trim_clr = 1'b0;
        base_fcw = 16'h1000;
        repeat (2) step();
        push_exp("rst_trim", KTrim, 32'd0);
        push_exp("rst_fcw", KFcw, 32'd0);
        push_exp("rst_phase", KPhase, 32'd0);
        push_exp("rst_sat", KSat, 32'd0);
        push_exp("rst_lock", KLock, 32'd0);
        reset = 1'b0;

        // NCO free run: fcw settles after one edge, phase wraps after 16 steps.
        step();
        push_exp("fcw_base", KFcw, 32'h1000);
        push_exp("phase_first", KPhase, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            push_exp("phase_ramp", KPhase, (i * 32'h1000) & 32'hFFFF);
        end
        en = 1'b0;
        repeat (3) step();
        push_exp("phase_hold_en0", KPhase, 32'd0);
        en = 1'b1;
        step();
        push_exp("phase_resume", KPhase, 32'h1000);

        // Held increase: one accept per 12-cycle frame.
        afc_en   = 1'b1;
        freq_mod = 2'b01;
        step();
        push_exp("inc_first", KTrim, 32'd1);
        repeat (11) step();
        push_exp("inc_holdoff", KTrim, 32'd1);
        step();
        push_exp("inc_second", KTrim, 32'd2);
        repeat (23) step();
        push_exp("inc_third", KTrim, 32'd3);
        push_exp("inc_fcw", KFcw, 32'h1003);
        push_exp("inc_lock", KLock, 32'd0);
        freq_mod = 2'b00;

        // Decrease during holdoff is dropped; at the frame boundary it lands.
        freq_mod = 2'b01;
        step();
        push_exp("pulse_accept", KTrim, 32'd4);
        freq_mod = 2'b00;
        repeat (4) step();
        freq_mod = 2'b10;
        step();
        freq_mod = 2'b00;
        push_exp("pulse_dropped", KTrim, 32'd4);
        repeat (6) step();
        freq_mod = 2'b10;
        step();
        push_exp("pulse_frame12", KTrim, 32'd3);
        freq_mod = 2'b00;

        // Positive rail saturation.
        trim_clr = 1'b1;
        step();
        trim_clr = 1'b0;
        push_exp("clr_trim", KTrim, 32'd0);
        push_exp("clr_lock", KLock, 32'd0);
        freq_mod = 2'b01;
        repeat (12 * 2046) step();
        push_exp("preload_2046", KTrim, 32'd2046);
        push_exp("preload_sat", KSat, 32'd0);
        repeat (36) step();
        push_exp("rail_trim", KTrim, 32'd2047);
        push_exp("rail_sat", KSat, 32'd1);
        push_exp("rail_fcw", KFcw, 32'h17FF);
        freq_mod = 2'b10;
        step();
        push_exp("off_rail_trim", KTrim, 32'd2046);
        push_exp("off_rail_sat", KSat, 32'd0);
        freq_mod = 2'b00;

        // Lock from alternating commands, lost on a repeated direction.
        trim_clr = 1'b1;
        step();
        trim_clr = 1'b0;
        for (int i = 0; i < 7; i++) begin
            freq_mod = alt_dirs[i];
            step();
            push_exp("alt_trim", KTrim, {20'd0, alt_trim[i]});
            push_exp("alt_lock", KLock, {31'd0, alt_lock[i]});
            freq_mod = 2'b00;
            repeat (11) step();
        end
        push_exp("neg_fcw", KFcw, 32'h0FFF);
        push_exp("neg_sat", KSat, 32'd0);

        // afc_en low holds trim but clears holdoff.
        freq_mod = 2'b01;
        step();
        push_exp("afc_pre", KTrim, 32'd0);
        afc_en = 1'b0;
        repeat (3) step();
        push_exp("afc_off_hold", KTrim, 32'd0);
        push_exp("afc_off_lock", KLock, 32'd0);
        afc_en = 1'b1;
        step();
        push_exp("afc_on_accept", KTrim, 32'd1);
        freq_mod = 2'b00;

        // trim_clr beats a simultaneous accept and leaves holdoff at zero.
        repeat (11) step();
        freq_mod = 2'b01;
        trim_clr = 1'b1;
        step();
        push_exp("clr_wins_trim", KTrim, 32'd0);
        push_exp("clr_wins_lock", KLock, 32'd0);
        trim_clr = 1'b0;
        step();
        push_exp("post_clr_accept", KTrim, 32'd1);
        freq_mod = 2'b00;
        step();
        push_exp("post_clr_fcw", KFcw, 32'h1001);
        push_exp("post_clr_sat", KSat, 32'd0);

        repeat (2) step();
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_trim_nco.md
Name: freq_trim_nco

Overview:
- Consumer end of the receiver AFC command interface.
- Accepts the 2-bit frequency-correction command (increase/decrease) emitted once per 12-cycle AFC frame and integrates it into a saturating signed trim word.
- Adds the trim word to a base frequency control word and drives a phase-accumulator NCO that re-tunes the local oscillator.
- Flags rail saturation and reports lock when commands dither about the correct frequency.

Parameters:
- TRIM_W, 12, width of the signed trim accumulator.
- FCW_W, 16, width of frequency control word and phase accumulator.
- STEP, 1, trim increment per accepted command (positive, < 2^(TRIM_W-2)).
- HOLDOFF, 12, en-qualified cycles after an accept during which further commands are ignored (one AFC frame).
- LOCK_CNT, 4, consecutive direction reversals required to assert lock.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  sample-rate enable; all state advances only when en=1, except trim_clr.
- afc_en  in  1  AFC enable; low disables command acceptance.
- freq_mod  in  2  command: 01 = increase, 10 = decrease, 00/11 = no-op.
- trim_clr  in  1  synchronous clear of trim, holdoff and lock state; no en qualification.
- base_fcw  in  FCW_W  nominal frequency control word, unsigned.
- trim_out  out  TRIM_W  signed trim value.
- fcw  out  FCW_W  registered base_fcw + sign-extended trim_out, modulo 2^FCW_W.
- phase  out  FCW_W  NCO phase accumulator.
- sat  out  1  high while trim_out is at either rail.
- lock  out  1  frequency-lock indicator.

Behaviour:
- Reset: the following are 0 asynchronously:
  - outputs trim_out, fcw, phase, sat, lock;
  - holdoff counter, alternation counter, last_dir.
- Accept condition: en & afc_en & (holdoff==0) & (freq_mod==01 or 10) & ~trim_clr.
- On accept:
  - trim <= trim + STEP for 01, trim − STEP for 10.
  - The result saturates to +(2^(TRIM_W-1)−1) / −2^(TRIM_W-1) and never wraps.
  - holdoff <= HOLDOFF−1.
- Holdoff counter:
  - Decrements by 1 on each en cycle when nonzero.
  - Forced to 0 when afc_en=0.
- Commands arriving while holdoff≠0 are dropped, not queued.
- sat: combinational from the trim register; 1 when trim equals either rail.
- Lock tracking, updated on accept only:
  - If dir ≠ last_dir and last_dir is valid: alt_cnt <= min(alt_cnt+1, LOCK_CNT).
  - Otherwise: alt_cnt <= 0.
  - last_dir <= dir and is marked valid.
- lock: registered 1 when alt_cnt==LOCK_CNT. Cleared on a same-direction accept, afc_en=0, trim_clr, or reset.
- afc_en=0: trim holds its value (not cleared); holdoff, alt_cnt, last_dir valid and lock are cleared.
- trim_clr:
  - Clears trim, holdoff, alt_cnt, last_dir valid and lock on the next edge.
  - Wins over a simultaneous accept; that command is dropped and holdoff is not loaded.
- fcw: registered every clk (no en qualification) from the current base_fcw and the trim register; 1-cycle latency from a trim change to fcw.
- Phase accumulator: phase <= phase + fcw on en cycles, wrapping modulo 2^FCW_W; holds otherwise.
- Latency:
  - Accept at edge N → trim_out new at N.
  - fcw new at N+1.
  - First phase step using the new fcw at the first en edge ≥ N+2.
- freq_mod is sampled only on accept-eligible cycles; values on other cycles have no effect.

Test Plan:
1. Reset, base_fcw=0x1000, en=1 continuous → fcw=0x1000 by cycle 1; phase increases by 0x1000 per cycle and wraps to 0x0000 after 16 steps.
2. afc_en=1, freq_mod=01 held for 36 en cycles → exactly 3 accepts (cycles 0, 12, 24); trim_out=3; fcw=0x1003.
3. freq_mod=10 pulsed at cycle 5 after an accept at cycle 0 → dropped (holdoff); trim unchanged. Pulse at cycle 12 → trim −1.
4. Preload trim to 2046 via 2046 accepts of 01, then 3 more accepts of 01 → trim_out=2047; sat=1; no wrap. Then one 10 accept → 2046; sat=0.
5. Alternating 01/10 commands, one per frame → lock=1 after the 5th accept. Next 10 following a 10 → lock=0.
6. trim_clr asserted on the same cycle as an eligible 01 → trim_out=0, lock=0, holdoff=0. An 01 on the following cycle is accepted → trim=1.
